dn_write_scheduler: RTL and testbench
=====================================

// Module: dn_write_scheduler
// PURPOSE
//  Sequences ROM download writes from hps_io into the game core's shared program/graphics RAM.
//  Buffers ioctl writes in a small FIFO and drains them only in cycles the core does not own the RAM.
//  Asserts back-pressure to hps_io and holds the core in reset from download start until drain completes.
//  Sits between hps_io (ioctl_*) and the core's dn_* RAM write port.
// PARAMETERS
//  ADDR_W      16  download/RAM address width
//  DATA_W      8   download/RAM data width
//  FIFO_DEPTH  4   write FIFO entries; power of two, >=2
// PORTS
//  clk_sys       in   1       system clock; all logic on posedge
//  reset         in   1       asynchronous, active-high reset
//  dn_download   in   1       ioctl_download level from hps_io
//  dn_wr         in   1       ioctl_wr strobe; one byte per high cycle
//  dn_addr       in   ADDR_W  ioctl_addr (low bits)
//  dn_data       in   DATA_W  ioctl_dout
//  dn_wait       out  1       back-pressure to hps_io (ioctl_wait)
//  core_slot     in   1       1 = core owns RAM this cycle; no write permitted
//  ram_addr      out  ADDR_W  RAM write address
//  ram_data      out  DATA_W  RAM write data
//  ram_we        out  1       RAM write enable, one cycle per byte
//  core_reset    out  1       hold-reset for game core
//  dn_done       out  1       one-cycle pulse when download fully committed
//  overflow      out  1       sticky: a write was dropped (FIFO full)
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty (count=0, pointers 0); state IDLE; overflow 0.
//  States: IDLE -> LOAD on dn_download=1 (clears overflow, sets core_reset=1).
//    LOAD -> DRAIN on dn_download=0. DRAIN -> DONE when FIFO empty and no ram_we this cycle.
//    DRAIN -> LOAD if dn_download rises again (FIFO contents kept). DONE -> IDLE after 1 cycle.
//  core_reset = 1 in LOAD and DRAIN, 0 elsewhere (registered). dn_done = 1 only in DONE.
//  Push: dn_wr=1 and state LOAD (or IDLE->LOAD same cycle) and FIFO not full -> store {addr,data}.
//    dn_wr while full -> byte dropped, overflow<=1. dn_wr while dn_download=0 -> ignored.
//  Pop: registered; if FIFO non-empty and core_slot=0 at edge N, then at N+1 ram_we=1 with head entry.
//    Min latency push at edge N -> ram_we high after edge N+1. At most one write per cycle.
//    core_slot=1 -> ram_we=0 next cycle; entry held, order preserved (strict FIFO).
//  Simultaneous push+pop: count unchanged; pointers both advance, wrap modulo FIFO_DEPTH.
//  count width clog2(FIFO_DEPTH)+1; full = count==FIFO_DEPTH; empty = count==0.
//  dn_wait = registered (count >= FIFO_DEPTH-1); guards the 1-cycle hps_io response lag.
//  ram_addr/ram_data hold last written value when ram_we=0.
//  Reset mid-download: FIFO flushed, pending bytes lost, core_reset drops with reset; no dn_done.
// TESTING
//  1 byte A=0x0010 D=0x5A, core_slot=0 -> ram_we 1 cycle, addr 0x0010 data 0x5A, 2 edges after push.
//  Burst of 8 bytes, core_slot=1 constantly -> dn_wait=1 after 3 pushes, ram_we never; release -> 8 in order.
//  core_slot toggling 1/0, 16-byte stream 0x00..0x0F -> RAM sees all 16 bytes in order, no gaps lost.
//  Force dn_wr with FIFO full (ignore dn_wait) -> 5th byte dropped, overflow=1 until next download start.
//  dn_download falls with 3 queued -> core_reset stays 1 until 3rd ram_we, then dn_done 1-cycle pulse.
//  Assert reset during DRAIN with 2 queued -> all outputs 0 immediately, no ram_we, no dn_done.

Source files
------------

// File: rtl/dn_write_scheduler.sv
// ROM download write scheduler: buffers hps_io ioctl writes in a small FIFO and
// commits them to the shared core RAM only in cycles the core does not own it.
module dn_write_scheduler #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dn_download,
    input  logic              dn_wr,
    input  logic [ADDR_W-1:0] dn_addr,
    input  logic [DATA_W-1:0] dn_data,
    output logic              dn_wait,
    input  logic              core_slot,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              core_reset,
    output logic              dn_done,
    output logic              overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_n;

    logic full, empty;
    logic push_req, push, drop, pop;
    logic clr_ovf, wait_n;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (dn_download) state_n = ST_LOAD;
            ST_LOAD:  if (!dn_download) state_n = ST_DRAIN;
            ST_DRAIN: begin
                if (dn_download)
                    state_n = ST_LOAD;
                else if (empty && !ram_we)
                    state_n = ST_DONE;
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // A write is accepted whenever the download level is high and we are
    // (or are about to be) loading; DONE is a one-cycle bookkeeping state.
    always_comb begin
        push_req = dn_wr && dn_download && (state != ST_DONE);
        push     = push_req && !full;
        drop     = push_req && full;
        pop      = !empty && !core_slot;
        clr_ovf  = (state == ST_IDLE) && dn_download;
        count_n  = count;
        case ({push, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
        // Threshold one below full leaves room for the write already in flight
        // while hps_io reacts to the wait signal.
        wait_n = (count_n >= CNT_W'(FIFO_DEPTH - 1));
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= dn_addr;
            fifo_data[wr_ptr] <= dn_data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_we     <= 1'b0;
            core_reset <= 1'b0;
            dn_done    <= 1'b0;
            overflow   <= 1'b0;
            dn_wait    <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            dn_wait <= wait_n;
            ram_we  <= pop;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                ram_addr <= fifo_addr[rd_ptr];
                ram_data <= fifo_data[rd_ptr];
            end
            core_reset <= (state_n == ST_LOAD) || (state_n == ST_DRAIN);
            dn_done    <= (state_n == ST_DONE);
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dn_write_scheduler.sv
// Directed bench for dn_write_scheduler: single write, back-pressure, slot
// arbitration, overflow, drain completion and reset during drain.
module tb_dn_write_scheduler;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dn_download;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wait;
    logic        core_slot;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_we;
    logic        core_reset;
    logic        dn_done;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [23:0] cap_q [$];

    dn_write_scheduler #(
        .ADDR_W     (16),
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .dn_download (dn_download),
        .dn_wr       (dn_wr),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data),
        .dn_wait     (dn_wait),
        .core_slot   (core_slot),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_we      (ram_we),
        .core_reset  (core_reset),
        .dn_done     (dn_done),
        .overflow    (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys)
        if (ram_we === 1'b1)
            cap_q.push_back({ram_addr, ram_data});

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            if (dn_done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [4:0] got;
        reset = 1'b1; dn_download = 1'b0; dn_wr = 1'b0;
        dn_addr = '0; dn_data = '0; core_slot = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        got = {ram_we, core_reset, dn_done, overflow, dn_wait};
        total++;
        if (got !== 5'b0 || ram_addr !== 16'h0 || ram_data !== 8'h0) begin
            $display("FAIL reset_outputs got=%b/%h/%h want=00000/0000/00", got, ram_addr, ram_data);
            bad++;
        end
        reset = 1'b0;
        step();
        got = {ram_we, core_reset, dn_done, overflow, dn_wait};
        total++;
        if (got !== 5'b0) begin
            $display("FAIL idle_after_reset got=%b want=00000", got);
            bad++;
        end
    endtask

    task automatic test_single_byte();
        logic [1:0] got;
        bit seen;
        dn_download = 1'b1; dn_wr = 1'b1; dn_addr = 16'h0010; dn_data = 8'h5A; core_slot = 1'b0;
        step();
        dn_wr = 1'b0;
        total++;
        if (ram_we !== 1'b0 || core_reset !== 1'b1) begin
            $display("FAIL single_edge1 we=%b crst=%b want we=0 crst=1", ram_we, core_reset);
            bad++;
        end
        step();
        total++;
        if (ram_we !== 1'b1 || ram_addr !== 16'h0010 || ram_data !== 8'h5A) begin
            $display("FAIL single_write we=%b addr=%h data=%h want 1/0010/5a", ram_we, ram_addr, ram_data);
            bad++;
        end
        step();
        total++;
        if (ram_we !== 1'b0 || ram_addr !== 16'h0010 || ram_data !== 8'h5A) begin
            $display("FAIL single_hold we=%b addr=%h data=%h want 0/0010/5a", ram_we, ram_addr, ram_data);
            bad++;
        end
        dn_download = 1'b0;
        step();
        got = {core_reset, dn_done};
        total++;
        if (got !== 2'b10) begin
            $display("FAIL single_drain crst_done=%b want=10", got);
            bad++;
        end
        step();
        got = {core_reset, dn_done};
        total++;
        if (got !== 2'b01) begin
            $display("FAIL single_done crst_done=%b want=01", got);
            bad++;
        end
        step();
        got = {core_reset, dn_done};
        total++;
        if (got !== 2'b00) begin
            $display("FAIL single_idle crst_done=%b want=00", got);
            bad++;
        end
        seen = 1'b0;
    endtask

    task automatic test_burst_backpressure();
        int base, sent, cyc;
        bit we_seen, seen;
        logic [23:0] exp_e;
        base = cap_q.size();
        core_slot = 1'b1; dn_download = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dn_wr = 1'b1; dn_addr = 16'h0200 + 16'(i); dn_data = 8'hA0 + 8'(i);
            step();
            total++;
            if (dn_wait !== (i == 2)) begin
                $display("FAIL burst_wait_%0d got=%b want=%b", i, dn_wait, (i == 2));
                bad++;
            end
        end
        dn_addr = 16'h0203; dn_data = 8'hA3;
        step();
        dn_wr = 1'b0;
        we_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (ram_we !== 1'b0) we_seen = 1'b1;
            step();
        end
        total++;
        if (we_seen || dn_wait !== 1'b1 || overflow !== 1'b0) begin
            $display("FAIL burst_hold we_seen=%b wait=%b ovf=%b want 0/1/0", we_seen, dn_wait, overflow);
            bad++;
        end
        core_slot = 1'b0;
        sent = 4; cyc = 0;
        while ((sent < 8 || (cap_q.size() - base) < 8) && cyc < 60) begin
            if (sent < 8 && !dn_wait) begin
                dn_wr = 1'b1; dn_addr = 16'h0200 + 16'(sent); dn_data = 8'hA0 + 8'(sent);
                sent++;
            end else begin
                dn_wr = 1'b0;
            end
            step();
            cyc++;
        end
        dn_wr = 1'b0;
        step();
        total++;
        if (cap_q.size() - base != 8) begin
            $display("FAIL burst_count got=%0d want=8", cap_q.size() - base);
            bad++;
        end
        for (int i = 0; i < 8 && i < cap_q.size() - base; i++) begin
            exp_e = {16'h0200 + 16'(i), 8'hA0 + 8'(i)};
            total++;
            if (cap_q[base + i] !== exp_e) begin
                $display("FAIL burst_entry_%0d got=%h want=%h", i, cap_q[base + i], exp_e);
                bad++;
            end
        end
        total++;
        if (overflow !== 1'b0) begin
            $display("FAIL burst_overflow got=%b want=0", overflow);
            bad++;
        end
        dn_download = 1'b0;
        wait_done(seen);
        total++;
        if (!seen) begin
            $display("FAIL burst_done_timeout got=0 want=1");
            bad++;
        end
        step();
    endtask

    task automatic test_toggle_stream();
        int base, sent, cyc;
        bit seen;
        logic [23:0] exp_e;
        base = cap_q.size();
        dn_download = 1'b1; core_slot = 1'b1;
        sent = 0; cyc = 0;
        while ((sent < 16 || (cap_q.size() - base) < 16) && cyc < 200) begin
            if (sent < 16 && !dn_wait) begin
                dn_wr = 1'b1; dn_addr = 16'h0300 + 16'(sent); dn_data = 8'(sent);
                sent++;
            end else begin
                dn_wr = 1'b0;
            end
            core_slot = ~core_slot;
            step();
            cyc++;
        end
        dn_wr = 1'b0; core_slot = 1'b0;
        step();
        total++;
        if (cap_q.size() - base != 16) begin
            $display("FAIL toggle_count got=%0d want=16", cap_q.size() - base);
            bad++;
        end
        for (int i = 0; i < 16 && i < cap_q.size() - base; i++) begin
            exp_e = {16'h0300 + 16'(i), 8'(i)};
            total++;
            if (cap_q[base + i] !== exp_e) begin
                $display("FAIL toggle_entry_%0d got=%h want=%h", i, cap_q[base + i], exp_e);
                bad++;
            end
        end
        total++;
        if (overflow !== 1'b0) begin
            $display("FAIL toggle_overflow got=%b want=0", overflow);
            bad++;
        end
        dn_download = 1'b0;
        wait_done(seen);
        total++;
        if (!seen) begin
            $display("FAIL toggle_done_timeout got=0 want=1");
            bad++;
        end
        step();
    endtask

    task automatic test_overflow();
        int base, cyc;
        bit seen;
        logic [23:0] exp_e;
        base = cap_q.size();
        dn_download = 1'b1; core_slot = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dn_wr = 1'b1; dn_addr = 16'h0400 + 16'(i); dn_data = 8'hC0 + 8'(i);
            step();
            total++;
            if (overflow !== (i == 4)) begin
                $display("FAIL ovf_push_%0d got=%b want=%b", i, overflow, (i == 4));
                bad++;
            end
        end
        dn_wr = 1'b0; core_slot = 1'b0;
        cyc = 0;
        while ((cap_q.size() - base) < 4 && cyc < 30) begin
            step();
            cyc++;
        end
        repeat (3) step();
        total++;
        if (cap_q.size() - base != 4) begin
            $display("FAIL ovf_count got=%0d want=4", cap_q.size() - base);
            bad++;
        end
        for (int i = 0; i < 4 && i < cap_q.size() - base; i++) begin
            exp_e = {16'h0400 + 16'(i), 8'hC0 + 8'(i)};
            total++;
            if (cap_q[base + i] !== exp_e) begin
                $display("FAIL ovf_entry_%0d got=%h want=%h", i, cap_q[base + i], exp_e);
                bad++;
            end
        end
        dn_download = 1'b0;
        wait_done(seen);
        total++;
        if (!seen || overflow !== 1'b1) begin
            $display("FAIL ovf_sticky done=%b ovf=%b want 1/1", seen, overflow);
            bad++;
        end
        step();
        total++;
        if (overflow !== 1'b1) begin
            $display("FAIL ovf_sticky_idle got=%b want=1", overflow);
            bad++;
        end
        dn_download = 1'b1;
        step();
        total++;
        if (overflow !== 1'b0 || core_reset !== 1'b1) begin
            $display("FAIL ovf_clear ovf=%b crst=%b want 0/1", overflow, core_reset);
            bad++;
        end
        dn_download = 1'b0;
        wait_done(seen);
        step();
    endtask

    task automatic test_drain_done();
        int base;
        logic [2:0] got;
        logic [2:0] exp_t [6];
        logic [23:0] exp_e;
        exp_t = '{3'b110, 3'b110, 3'b110, 3'b010, 3'b001, 3'b000};
        base = cap_q.size();
        dn_download = 1'b1; core_slot = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dn_wr = 1'b1; dn_addr = 16'h0500 + 16'(i); dn_data = 8'hD0 + 8'(i);
            step();
        end
        dn_wr = 1'b0; dn_download = 1'b0;
        step();
        step();
        got = {ram_we, core_reset, dn_done};
        total++;
        if (got !== 3'b010) begin
            $display("FAIL drain_held we_crst_done=%b want=010", got);
            bad++;
        end
        core_slot = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            got = {ram_we, core_reset, dn_done};
            total++;
            if (got !== exp_t[i]) begin
                $display("FAIL drain_cycle_%0d we_crst_done=%b want=%b", i, got, exp_t[i]);
                bad++;
            end
        end
        total++;
        if (cap_q.size() - base != 3) begin
            $display("FAIL drain_count got=%0d want=3", cap_q.size() - base);
            bad++;
        end
        for (int i = 0; i < 3 && i < cap_q.size() - base; i++) begin
            exp_e = {16'h0500 + 16'(i), 8'hD0 + 8'(i)};
            total++;
            if (cap_q[base + i] !== exp_e) begin
                $display("FAIL drain_entry_%0d got=%h want=%h", i, cap_q[base + i], exp_e);
                bad++;
            end
        end
    endtask

    task automatic test_reset_in_drain();
        int base;
        bit any_act;
        logic [4:0] got;
        base = cap_q.size();
        dn_download = 1'b1; core_slot = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dn_wr = 1'b1; dn_addr = 16'h0600 + 16'(i); dn_data = 8'hE0 + 8'(i);
            step();
        end
        dn_wr = 1'b0; dn_download = 1'b0;
        step();
        total++;
        if (core_reset !== 1'b1) begin
            $display("FAIL rstdrain_pre crst=%b want=1", core_reset);
            bad++;
        end
        #2;
        reset = 1'b1;
        #1;
        got = {ram_we, core_reset, dn_done, overflow, dn_wait};
        total++;
        if (got !== 5'b0 || ram_addr !== 16'h0 || ram_data !== 8'h0) begin
            $display("FAIL rstdrain_async got=%b/%h/%h want=00000/0000/00", got, ram_addr, ram_data);
            bad++;
        end
        core_slot = 1'b0;
        step();
        reset = 1'b0;
        any_act = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (ram_we !== 1'b0 || dn_done !== 1'b0 || core_reset !== 1'b0) any_act = 1'b1;
        end
        total++;
        if (any_act || cap_q.size() != base) begin
            $display("FAIL rstdrain_quiet activity=%b writes=%0d want 0/0", any_act, cap_q.size() - base);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst_backpressure();
        test_toggle_stream();
        test_overflow();
        test_drain_done();
        test_reset_in_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
